// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared sizes and state encoding for the job-assignment cost server
//
// Purpose: the widths of the cost matrix, solver results and counters, plus the
// server state enum. The top level and the cost memory both import this package.
// Ports: none (package).

package jam_pkg;

   localparam int N_WORKER  = 8;
   localparam int COST_W    = 7;
   localparam int MINCOST_W = 10;
   localparam int COUNT_W   = 4;
   localparam int ADDR_W    = 6;
   localparam int IDX_W     = 3;
   localparam int N_ENTRY   = N_WORKER * N_WORKER;
   localparam int CHECK_W   = 13;
   localparam int CYCLE_W   = 20;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SERVE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/jam_cost_mem.sv
// rtl/jam_cost_mem.sv - 64 x 7 cost register file, one write port, one registered read port
//
// Purpose: holds the worker/job cost matrix. Contents survive reset and clear;
// the next load simply overwrites them, so there is deliberately no reset here.
// Ports:
//   clk      clock, rising edge
//   wr_en    write strobe
//   wr_addr  write address (row-major W*8+J)
//   wr_data  cost to store
//   rd_en    read strobe; rd_data updates only when set
//   rd_addr  read address
//   rd_data  registered read data

module jam_cost_mem
   import jam_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [COST_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [COST_W-1:0] rd_data
);

   logic [COST_W-1:0] mem [N_ENTRY];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/jam_cost_server.sv
// rtl/jam_cost_server.sv - responder for the solver cost interface with load, serve and capture
//
// Purpose: loads an 8x8 cost matrix beat by beat, serves Cost = mem[{W,J}] to the
// solver with one cycle of latency, and captures the solver result on Valid, or
// gives up after TIMEOUT serve cycles. Also tracks load checksum, address
// coverage and serve cycle count.
// Ports:
//   CLK, RST (async active-low), CLR (sync clear back to IDLE)
//   LD_VALID/LD_DATA/LD_READY   load stream, row-major
//   LOADED                      all 64 entries written
//   W, J -> Cost                cost lookup, registered
//   MinCost, MatchCount, Valid  solver result
//   RES_COST, RES_COUNT, RES_CYCLES, CHECKSUM, ALL_READ, DONE, TIMED_OUT  status

module jam_cost_server
   import jam_pkg::*;
#(
   parameter logic [CYCLE_W-1:0] TIMEOUT = 20'd1_000_000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLR,
   input  logic                 LD_VALID,
   input  logic [COST_W-1:0]    LD_DATA,
   output logic                 LD_READY,
   output logic                 LOADED,
   input  logic [IDX_W-1:0]     W,
   input  logic [IDX_W-1:0]     J,
   output logic [COST_W-1:0]    Cost,
   input  logic [MINCOST_W-1:0] MinCost,
   input  logic [COUNT_W-1:0]   MatchCount,
   input  logic                 Valid,
   output logic [MINCOST_W-1:0] RES_COST,
   output logic [COUNT_W-1:0]   RES_COUNT,
   output logic [CYCLE_W-1:0]   RES_CYCLES,
   output logic [CHECK_W-1:0]   CHECKSUM,
   output logic                 ALL_READ,
   output logic                 DONE,
   output logic                 TIMED_OUT
);

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   ptr;
   logic [N_ENTRY-1:0]  seen;
   logic [COST_W-1:0]   rd_data;
   logic                cost_vld;
   logic                beat;
   logic                serving;
   logic                valid_hit;
   logic                timeout_hit;
   logic [CYCLE_W-1:0]  cycles_inc;

   // Saturating next value of the serve cycle counter.
   assign cycles_inc = (RES_CYCLES == '1) ? RES_CYCLES : RES_CYCLES + CYCLE_W'(1);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      LD_READY    = 1'b0;
      beat        = 1'b0;
      valid_hit   = 1'b0;
      timeout_hit = 1'b0;
      serving     = 1'b0;
      case (state)
         ST_IDLE: begin
            LD_READY = 1'b1;
            beat     = LD_VALID;
            if (LD_VALID) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            LD_READY = 1'b1;
            beat     = LD_VALID;
            if (LD_VALID && ptr == ADDR_W'(N_ENTRY - 1)) begin
               state_next = ST_SERVE;
            end
         end
         ST_SERVE: begin
            serving = 1'b1;
            // Valid beats a coinciding timeout.
            if (Valid) begin
               valid_hit  = 1'b1;
               state_next = ST_DONE;
            end else if (cycles_inc >= TIMEOUT) begin
               timeout_hit = 1'b1;
               state_next  = ST_DONE;
            end
         end
         ST_DONE: begin
            serving = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      // Clear overrides every other event in the same cycle.
      if (CLR) begin
         state_next  = ST_IDLE;
         beat        = 1'b0;
         valid_hit   = 1'b0;
         timeout_hit = 1'b0;
      end
   end

   assign LOADED   = (state == ST_SERVE) || (state == ST_DONE);
   assign DONE     = (state == ST_DONE);
   assign ALL_READ = &seen;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr        <= '0;
         CHECKSUM   <= '0;
         seen       <= '0;
         RES_CYCLES <= '0;
         RES_COST   <= '0;
         RES_COUNT  <= '0;
         TIMED_OUT  <= 1'b0;
         cost_vld   <= 1'b0;
      end else if (CLR) begin
         ptr        <= '0;
         CHECKSUM   <= '0;
         seen       <= '0;
         RES_CYCLES <= '0;
         RES_COST   <= '0;
         RES_COUNT  <= '0;
         TIMED_OUT  <= 1'b0;
      end else begin
         if (beat) begin
            ptr      <= ptr + ADDR_W'(1);
            CHECKSUM <= CHECKSUM + {{(CHECK_W - COST_W){1'b0}}, LD_DATA};
         end
         if (state == ST_SERVE) begin
            seen[{W, J}] <= 1'b1;
            if (valid_hit) begin
               RES_COST  <= MinCost;
               RES_COUNT <= MatchCount;
            end else begin
               RES_CYCLES <= cycles_inc;
            end
            if (timeout_hit) begin
               TIMED_OUT <= 1'b1;
            end
         end
         // The memory read register has no reset; Cost reads as 0 until it
         // has been loaded once after reset.
         if (serving) begin
            cost_vld <= 1'b1;
         end
      end
   end

   jam_cost_mem u_mem (
      .clk     (CLK),
      .wr_en   (beat),
      .wr_addr (ptr),
      .wr_data (LD_DATA),
      .rd_en   (serving),
      .rd_addr ({W, J}),
      .rd_data (rd_data)
   );

   assign Cost = cost_vld ? rd_data : '0;

endmodule

// File: tb/tb_jam_cost_server.sv
// tb/tb_jam_cost_server.sv - directed self-checking bench for jam_cost_server

module tb_jam_cost_server;

   logic        CLK;
   logic        RST;
   logic        CLR;
   logic        LD_VALID;
   logic [6:0]  LD_DATA;
   logic        LD_READY;
   logic        LOADED;
   logic [2:0]  W;
   logic [2:0]  J;
   logic [6:0]  Cost;
   logic [9:0]  MinCost;
   logic [3:0]  MatchCount;
   logic        Valid;
   logic [9:0]  RES_COST;
   logic [3:0]  RES_COUNT;
   logic [19:0] RES_CYCLES;
   logic [12:0] CHECKSUM;
   logic        ALL_READ;
   logic        DONE;
   logic        TIMED_OUT;

   jam_cost_server #(.TIMEOUT(20'd100)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CLR        (CLR),
      .LD_VALID   (LD_VALID),
      .LD_DATA    (LD_DATA),
      .LD_READY   (LD_READY),
      .LOADED     (LOADED),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .MinCost    (MinCost),
      .MatchCount (MatchCount),
      .Valid      (Valid),
      .RES_COST   (RES_COST),
      .RES_COUNT  (RES_COUNT),
      .RES_CYCLES (RES_CYCLES),
      .CHECKSUM   (CHECKSUM),
      .ALL_READ   (ALL_READ),
      .DONE       (DONE),
      .TIMED_OUT  (TIMED_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         ticks = 0;
   int         t0    = 0;
   int         sum   = 0;
   logic [6:0] model [64];
   logic [6:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      ticks++;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ld_ready"}, 32'(LD_READY), 1);
      check({tag, "_loaded"}, 32'(LOADED), 0);
      check({tag, "_cost"}, 32'(Cost), 0);
      check({tag, "_res_cost"}, 32'(RES_COST), 0);
      check({tag, "_res_count"}, 32'(RES_COUNT), 0);
      check({tag, "_res_cycles"}, 32'(RES_CYCLES), 0);
      check({tag, "_checksum"}, 32'(CHECKSUM), 0);
      check({tag, "_all_read"}, 32'(ALL_READ), 0);
      check({tag, "_done"}, 32'(DONE), 0);
      check({tag, "_timed_out"}, 32'(TIMED_OUT), 0);
   endtask

   // mode 0: cost = 8W+J; otherwise random costs.
   task automatic load_matrix(input int mode);
      sum = 0;
      for (int i = 0; i < 64; i++) begin
         model[i] = (mode == 0) ? 7'(i) : 7'($urandom_range(0, 127));
         sum += int'(model[i]);
         LD_VALID = 1'b1;
         LD_DATA  = model[i];
         tick();
         if (i == 62) check("loaded_before_last", 32'(LOADED), 0);
      end
      LD_VALID = 1'b0;
      t0 = ticks;
      check("loaded", 32'(LOADED), 1);
      check("ld_ready_serve", 32'(LD_READY), 0);
      check("checksum", 32'(CHECKSUM), 32'(sum));
   endtask

   // Scoreboard read: expected cost queued when the address is driven,
   // popped when the registered Cost appears.
   task automatic serve_read(input int addr);
      W = addr[5:3];
      J = addr[2:0];
      exp_q.push_back(model[addr]);
      tick();
      check("cost", 32'(Cost), 32'(exp_q.pop_front()));
   endtask

   initial begin
      int n;
      RST = 1'b0; CLR = 1'b0; LD_VALID = 1'b0; LD_DATA = '0;
      W = '0; J = '0; MinCost = '0; MatchCount = '0; Valid = 1'b0;
      repeat (3) tick();
      check_reset_state("rst_low");
      RST = 1'b1;
      tick();
      check_reset_state("rst");
      repeat (5) tick();
      check_reset_state("idle5");

      // Valid outside SERVE is ignored.
      Valid = 1'b1; MinCost = 10'd77; MatchCount = 4'd3;
      tick();
      Valid = 1'b0;
      check("idle_valid_res", 32'(RES_COST), 0);
      check("idle_valid_done", 32'(DONE), 0);

      // Load 8W+J, then a 65th beat that must be ignored.
      load_matrix(0);
      check("checksum_2016", 32'(CHECKSUM), 2016);
      LD_VALID = 1'b1; LD_DATA = 7'd99;
      tick();
      LD_VALID = 1'b0;
      check("beat65_checksum", 32'(CHECKSUM), 2016);
      check("beat65_loaded", 32'(LOADED), 1);

      serve_read(3 * 8 + 5);
      check("cost_w3j5", 32'(Cost), 29);
      serve_read(63);
      check("cost_w7j7", 32'(Cost), 63);
      check("all_read_partial", 32'(ALL_READ), 0);

      for (int a = 0; a < 64; a++) serve_read(a);
      check("all_read", 32'(ALL_READ), 1);

      n = ticks - t0;
      Valid = 1'b1; MinCost = 10'd56; MatchCount = 4'd8;
      tick();
      Valid = 1'b0;
      check("res_cost", 32'(RES_COST), 56);
      check("res_count", 32'(RES_COUNT), 8);
      check("res_cycles", 32'(RES_CYCLES), 32'(n));
      check("done", 32'(DONE), 1);
      check("timed_out_zero", 32'(TIMED_OUT), 0);

      Valid = 1'b1; MinCost = 10'd12; MatchCount = 4'd1;
      tick();
      Valid = 1'b0;
      check("second_valid_cost", 32'(RES_COST), 56);
      check("second_valid_count", 32'(RES_COUNT), 8);
      serve_read(1 * 8 + 2);
      LD_VALID = 1'b1; LD_DATA = 7'd5;
      tick();
      LD_VALID = 1'b0;
      check("done_ld_ignored", 32'(CHECKSUM), 2016);

      // CLR from DONE.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      check("clr_done", 32'(DONE), 0);
      check("clr_loaded", 32'(LOADED), 0);
      check("clr_res_cost", 32'(RES_COST), 0);
      check("clr_checksum", 32'(CHECKSUM), 0);
      check("clr_all_read", 32'(ALL_READ), 0);
      check("clr_ld_ready", 32'(LD_READY), 1);

      // CLR after 10 load beats.
      for (int i = 0; i < 10; i++) begin
         LD_VALID = 1'b1; LD_DATA = 7'(100 + i);
         tick();
      end
      check("partial_checksum", 32'(CHECKSUM), 1045);
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      LD_VALID = 1'b0;
      check("clr_load_checksum", 32'(CHECKSUM), 0);
      check("clr_load_loaded", 32'(LOADED), 0);
      check("clr_load_ready", 32'(LD_READY), 1);

      // Reload random data; no Valid -> timeout after exactly 100 serve edges.
      load_matrix(1);
      n = 0;
      while (DONE !== 1'b1 && n < 200) begin
         serve_read(int'($urandom_range(0, 63)));
         n++;
      end
      check("timeout_edges", 32'(n), 100);
      check("timeout_done", 32'(DONE), 1);
      check("timeout_flag", 32'(TIMED_OUT), 1);
      check("timeout_cycles", 32'(RES_CYCLES), 100);
      check("timeout_res_cost", 32'(RES_COST), 0);
      check("timeout_res_count", 32'(RES_COUNT), 0);
      serve_read(17);

      // Valid on the timeout edge wins.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      load_matrix(1);
      for (int i = 0; i < 99; i++) serve_read(int'($urandom_range(0, 63)));
      check("pre_timeout_done", 32'(DONE), 0);
      Valid = 1'b1; MinCost = 10'd300; MatchCount = 4'd5;
      tick();
      Valid = 1'b0;
      check("race_done", 32'(DONE), 1);
      check("race_timed_out", 32'(TIMED_OUT), 0);
      check("race_res_cost", 32'(RES_COST), 300);
      check("race_res_count", 32'(RES_COUNT), 5);
      check("race_res_cycles", 32'(RES_CYCLES), 99);

      // Asynchronous reset in SERVE.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      load_matrix(0);
      serve_read(42);
      RST = 1'b0;
      #2;
      check_reset_state("rst_serve");
      tick();
      RST = 1'b1;
      tick();
      check_reset_state("rst_release");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
